// File: rtl/reset_req_gen.sv
// Reset request generator: merges sw/wdt/dbg requests into stretched reset events,
// handshakes with the downstream synchronized reset and records the cause.
module reset_req_gen #(
    parameter int unsigned PULSE_CYCLES = 16,
    parameter int unsigned ACK_TIMEOUT  = 64,
    parameter int unsigned COOL_CYCLES  = 4
) (
    input  logic       dclk,
    input  logic       arst_n,
    input  logic       scan_mode,
    input  logic       sw_req,
    input  logic       wdt_req,
    input  logic       dbg_req,
    input  logic       srst_ack_n,
    input  logic       cause_clr,
    output logic       rst_out_n,
    output logic       busy,
    output logic [2:0] cause,
    output logic       timeout_err
);

    localparam logic [7:0] PULSE_LD = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] COOL_LD  = 8'(COOL_CYCLES - 1);
    localparam logic [7:0] ACK_TO   = 8'(ACK_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ASSERT  = 2'd1,
        S_RELEASE = 2'd2,
        S_COOL    = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] timer_q, timer_d;
    logic       pend_q, pend_d;
    logic [2:0] cause_q, cause_d;
    logic       err_q, err_d;
    logic       rst_out_q, rst_out_d;
    logic       busy_q, busy_d;
    logic       to_err_s;
    logic       any_req_s;
    logic [2:0] set_s;

    assign any_req_s = sw_req | wdt_req | dbg_req | pend_q;

    // State and datapath registers
    always_ff @(posedge dclk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            timer_q   <= 8'd0;
            pend_q    <= 1'b0;
            cause_q   <= 3'd0;
            err_q     <= 1'b0;
            rst_out_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timer_q   <= timer_d;
            pend_q    <= pend_d;
            cause_q   <= cause_d;
            err_q     <= err_d;
            rst_out_q <= rst_out_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d  = state_q;
        to_err_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_req_s) state_d = S_ASSERT;
                else           state_d = S_IDLE;
            end
            S_ASSERT: begin
                if (cnt_q != 8'd0) begin
                    state_d = S_ASSERT;
                end else if (!srst_ack_n) begin
                    state_d = S_RELEASE;
                end else if (timer_q == ACK_TO) begin
                    state_d  = S_RELEASE;
                    to_err_s = 1'b1;
                end else begin
                    state_d = S_ASSERT;
                end
            end
            S_RELEASE: begin
                if (srst_ack_n) begin
                    state_d = S_COOL;
                end else if (timer_q == ACK_TO) begin
                    state_d  = S_COOL;
                    to_err_s = 1'b1;
                end else begin
                    state_d = S_RELEASE;
                end
            end
            S_COOL: begin
                if (cnt_q == 8'd0) state_d = S_IDLE;
                else               state_d = S_COOL;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Counter, ack timer, pending request and sticky status updates
    always_comb begin
        cnt_d   = cnt_q;
        timer_d = timer_q;
        pend_d  = pend_q;
        set_s   = 3'd0;
        if (state_d != state_q) begin
            timer_d = 8'd0;
            if (state_d == S_ASSERT)    cnt_d = PULSE_LD;
            else if (state_d == S_COOL) cnt_d = COOL_LD;
            else                        cnt_d = 8'd0;
        end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end else if ((state_q == S_ASSERT) || (state_q == S_RELEASE)) begin
            timer_d = timer_q + 8'd1;
        end else begin
            timer_d = timer_q;
        end

        // A request seen after the pulse would otherwise be lost; it restarts from IDLE.
        if (sw_req && ((state_q == S_RELEASE) || (state_q == S_COOL))) begin
            pend_d = 1'b1;
        end else if ((state_q == S_IDLE) && (state_d == S_ASSERT)) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end

        if ((state_q == S_IDLE) && (state_d == S_ASSERT)) begin
            set_s = {dbg_req, wdt_req, sw_req | pend_q};
        end else if (state_q == S_ASSERT) begin
            set_s = {dbg_req, wdt_req, sw_req};
        end else begin
            set_s = 3'd0;
        end

        cause_d = (cause_clr ? 3'd0 : cause_q) | set_s;
        err_d   = (cause_clr ? 1'b0 : err_q) | to_err_s;
    end

    // Registered output decode from the upcoming state
    always_comb begin
        rst_out_d = (state_d != S_ASSERT);
        busy_d    = (state_d != S_IDLE);
    end

    assign rst_out_n   = scan_mode ? arst_n : rst_out_q;
    assign busy        = busy_q;
    assign cause       = cause_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_reset_req_gen.sv
// Scenario bench for reset_req_gen: a monitor measures reset pulses, gaps and idle runs,
// and each scenario task compares them against expected values it queued itself.
module tb_reset_req_gen;

    localparam int PULSE   = 16;
    localparam int ACK_TO  = 64;
    localparam int COOL    = 4;
    localparam int ACK_DLY = 2;                      // downstream synchronizer depth
    localparam int REL_LEN = ACK_DLY + 1;            // cycles spent waiting for ack high
    localparam int GAP     = REL_LEN + COOL + 1;     // high cycles between back-to-back events

    logic       dclk = 1'b0;
    logic       clk_en = 1'b1;
    logic       arst_n, scan_mode, sw_req, wdt_req, dbg_req, cause_clr;
    logic       srst_ack_n;
    logic       rst_out_n, busy, timeout_err;
    logic [2:0] cause;
    logic       d1, d2;
    int         ack_mode;

    int errors = 0;
    int checks = 0;

    int exp_lo[$], exp_gap[$], exp_bl[$];
    int lo_obs[$], gap_obs[$], bl_obs[$], rb_obs[$];
    logic mon_rst = 1'b0;

    reset_req_gen #(.PULSE_CYCLES(PULSE), .ACK_TIMEOUT(ACK_TO), .COOL_CYCLES(COOL)) dut (
        .dclk(dclk), .arst_n(arst_n), .scan_mode(scan_mode), .sw_req(sw_req),
        .wdt_req(wdt_req), .dbg_req(dbg_req), .srst_ack_n(srst_ack_n),
        .cause_clr(cause_clr), .rst_out_n(rst_out_n), .busy(busy),
        .cause(cause), .timeout_err(timeout_err)
    );

    always #5 if (clk_en) dclk = ~dclk;

    always @(posedge dclk or negedge arst_n) begin
        if (!arst_n) begin
            d1 <= 1'b0;
            d2 <= 1'b0;
        end else begin
            d1 <= rst_out_n;
            d2 <= d1;
        end
    end

    assign srst_ack_n = (ack_mode == 1) ? 1'b1 : (ack_mode == 2) ? 1'b0 : d2;

    // Monitor: low-pulse lengths, high gaps, busy-low runs, release-to-idle lengths
    initial begin
        int  low_len, high_len, bl_len, rb_len;
        bit  prev_rst, prev_busy, seen_pulse, seen_bfall;
        low_len = 0; high_len = 0; bl_len = 0; rb_len = 0;
        prev_rst = 1'b1; prev_busy = 1'b0; seen_pulse = 1'b0; seen_bfall = 1'b0;
        forever begin
            @(negedge dclk);
            if (mon_rst) begin
                lo_obs.delete(); gap_obs.delete(); bl_obs.delete(); rb_obs.delete();
                low_len = 0; high_len = 0; bl_len = 0; rb_len = 0;
                prev_rst = 1'b1; prev_busy = busy; seen_pulse = 1'b0; seen_bfall = 1'b0;
            end else begin
                if (!rst_out_n) begin
                    if (prev_rst && seen_pulse) gap_obs.push_back(high_len);
                    if (prev_rst) low_len = 0;
                    low_len++;
                    rb_len = 0;
                end else begin
                    if (!prev_rst) begin
                        lo_obs.push_back(low_len);
                        seen_pulse = 1'b1;
                        high_len = 0;
                    end
                    high_len++;
                    if (busy) rb_len++;
                end
                prev_rst = rst_out_n;
                if (prev_busy && !busy) begin
                    rb_obs.push_back(rb_len);
                    bl_len = 0;
                    seen_bfall = 1'b1;
                end
                if (!busy) bl_len++;
                if (busy && !prev_busy && seen_bfall) bl_obs.push_back(bl_len);
                prev_busy = busy;
            end
        end
    end

    task automatic mon_clear();
        exp_lo.delete(); exp_gap.delete(); exp_bl.delete();
        mon_rst = 1'b1;
        @(negedge dclk);
        #1 mon_rst = 1'b0;
    endtask

    task automatic pulse_sw();
        sw_req = 1'b1;
        @(negedge dclk);
        sw_req = 1'b0;
    endtask

    task automatic wait_lo(input int n, input int budget, output bit ok);
        ok = 1'b0;
        repeat (budget) begin
            @(negedge dclk);
            #1;
            if (lo_obs.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        repeat (budget) begin
            @(negedge dclk);
            #1;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        arst_n = 1'b0; scan_mode = 1'b0; sw_req = 1'b0; wdt_req = 1'b0;
        dbg_req = 1'b0; cause_clr = 1'b0; ack_mode = 0;
        #1;
        checks++; if (rst_out_n !== 1'b0) begin errors++; $display("FAIL reset_rst_out: got %b expected 0", rst_out_n); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (cause !== 3'b000) begin errors++; $display("FAIL reset_cause: got %b expected 000", cause); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", timeout_err); end
        repeat (3) @(negedge dclk);
        arst_n = 1'b1;
        repeat (3) @(negedge dclk);
        checks++; if (rst_out_n !== 1'b1) begin errors++; $display("FAIL post_reset_release: got %b expected 1", rst_out_n); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_sw_pulse();
        bit ok; int got, e;
        mon_clear();
        exp_lo.push_back(PULSE);
        pulse_sw();
        checks++; if ({rst_out_n, busy} !== 2'b01) begin errors++; $display("FAIL sw_latency: got rst=%b busy=%b expected rst=0 busy=1", rst_out_n, busy); end
        wait_lo(1, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL sw_pulse_timeout: got no pulse expected one"); end
        got = (lo_obs.size() > 0) ? lo_obs.pop_front() : -1;
        e = exp_lo.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL sw_low_len: got %0d expected %0d", got, e); end
        wait_idle(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL sw_idle_timeout: got busy expected idle"); end
        got = (rb_obs.size() > 0) ? rb_obs.pop_front() : -1;
        checks++; if (got !== REL_LEN + COOL) begin errors++; $display("FAIL sw_release_to_idle: got %0d expected %0d", got, REL_LEN + COOL); end
        checks++; if (cause !== 3'b001) begin errors++; $display("FAIL sw_cause: got %b expected 001", cause); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL sw_err: got %b expected 0", timeout_err); end
    endtask

    task automatic test_wdt_level();
        bit ok; int got, e;
        mon_clear();
        cause_clr = 1'b1;
        @(negedge dclk);
        cause_clr = 1'b0;
        checks++; if (cause !== 3'b000) begin errors++; $display("FAIL wdt_cause_cleared: got %b expected 000", cause); end
        for (int i = 0; i < 3; i++) exp_lo.push_back(PULSE);
        for (int i = 0; i < 2; i++) begin exp_gap.push_back(GAP); exp_bl.push_back(1); end
        wdt_req = 1'b1;
        wait_lo(3, 400, ok);
        wdt_req = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL wdt_pulses_timeout: got %0d pulses expected 3", lo_obs.size()); end
        checks++; if (cause !== 3'b010) begin errors++; $display("FAIL wdt_cause: got %b expected 010", cause); end
        while (exp_lo.size() > 0) begin
            got = (lo_obs.size() > 0) ? lo_obs.pop_front() : -1;
            e = exp_lo.pop_front();
            checks++; if (got !== e) begin errors++; $display("FAIL wdt_low_len: got %0d expected %0d", got, e); end
        end
        while (exp_gap.size() > 0) begin
            got = (gap_obs.size() > 0) ? gap_obs.pop_front() : -1;
            e = exp_gap.pop_front();
            checks++; if (got !== e) begin errors++; $display("FAIL wdt_gap: got %0d expected %0d", got, e); end
            got = (bl_obs.size() > 0) ? bl_obs.pop_front() : -1;
            e = exp_bl.pop_front();
            checks++; if (got !== e) begin errors++; $display("FAIL wdt_idle_run: got %0d expected %0d", got, e); end
        end
        wait_idle(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wdt_idle_timeout: got busy expected idle"); end
    endtask

    task automatic test_pending();
        bit ok; int got, e;
        int dly[2] = '{1, 4};                        // sw_req lands in RELEASE, then in COOL
        foreach (dly[k]) begin
            mon_clear();
            exp_lo.push_back(PULSE); exp_lo.push_back(PULSE);
            exp_gap.push_back(GAP); exp_bl.push_back(1);
            pulse_sw();
            wait_lo(1, 200, ok);
            repeat (dly[k]) @(negedge dclk);
            pulse_sw();
            wait_lo(2, 200, ok);
            checks++; if (!ok) begin errors++; $display("FAIL pend_second_event d=%0d: got %0d pulses expected 2", dly[k], lo_obs.size()); end
            while (exp_lo.size() > 0) begin
                got = (lo_obs.size() > 0) ? lo_obs.pop_front() : -1;
                e = exp_lo.pop_front();
                checks++; if (got !== e) begin errors++; $display("FAIL pend_low_len d=%0d: got %0d expected %0d", dly[k], got, e); end
            end
            got = (gap_obs.size() > 0) ? gap_obs.pop_front() : -1;
            e = exp_gap.pop_front();
            checks++; if (got !== e) begin errors++; $display("FAIL pend_gap d=%0d: got %0d expected %0d", dly[k], got, e); end
            got = (bl_obs.size() > 0) ? bl_obs.pop_front() : -1;
            e = exp_bl.pop_front();
            checks++; if (got !== e) begin errors++; $display("FAIL pend_idle_run d=%0d: got %0d expected %0d", dly[k], got, e); end
            wait_idle(200, ok);
        end
    endtask

    task automatic test_assert_absorb();
        bit ok; int got, e;
        mon_clear();
        cause_clr = 1'b1;
        @(negedge dclk);
        cause_clr = 1'b0;
        exp_lo.push_back(PULSE);
        pulse_sw();
        repeat (5) @(negedge dclk);
        pulse_sw();
        wait_lo(1, 200, ok);
        wait_idle(200, ok);
        repeat (20) @(negedge dclk);
        #1;
        got = (lo_obs.size() > 0) ? lo_obs.pop_front() : -1;
        e = exp_lo.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL absorb_low_len: got %0d expected %0d", got, e); end
        checks++; if (lo_obs.size() !== 0) begin errors++; $display("FAIL absorb_extra_event: got %0d extra pulses expected 0", lo_obs.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL absorb_busy: got %b expected 0", busy); end
        checks++; if (cause !== 3'b001) begin errors++; $display("FAIL absorb_cause: got %b expected 001", cause); end
    endtask

    task automatic test_timeout();
        bit ok; int got, e;
        mon_clear();
        ack_mode = 1;
        exp_lo.push_back(PULSE + ACK_TO);
        pulse_sw();
        wait_lo(1, 300, ok);
        got = (lo_obs.size() > 0) ? lo_obs.pop_front() : -1;
        e = exp_lo.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL timeout_low_len: got %0d expected %0d", got, e); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_err_set: got %b expected 1", timeout_err); end
        wait_idle(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL timeout_idle: got busy expected idle"); end
        got = (rb_obs.size() > 0) ? rb_obs.pop_front() : -1;
        checks++; if (got !== 1 + COOL) begin errors++; $display("FAIL timeout_release_to_idle: got %0d expected %0d", got, 1 + COOL); end
        ack_mode = 0;
    endtask

    task automatic test_cause_clr();
        bit ok; int got, e;
        mon_clear();
        exp_lo.push_back(PULSE);
        dbg_req = 1'b1; cause_clr = 1'b1;
        @(negedge dclk);
        dbg_req = 1'b0; cause_clr = 1'b0;
        checks++; if (cause !== 3'b100) begin errors++; $display("FAIL clr_dbg_cause: got %b expected 100", cause); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL clr_err: got %b expected 0", timeout_err); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clr_dbg_busy: got %b expected 1", busy); end
        wait_lo(1, 200, ok);
        got = (lo_obs.size() > 0) ? lo_obs.pop_front() : -1;
        e = exp_lo.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL clr_dbg_low_len: got %0d expected %0d", got, e); end
        wait_idle(200, ok);
    endtask

    task automatic test_release_timeout();
        bit ok; int got, e;
        mon_clear();
        ack_mode = 2;
        exp_lo.push_back(PULSE);
        pulse_sw();
        wait_lo(1, 200, ok);
        got = (lo_obs.size() > 0) ? lo_obs.pop_front() : -1;
        e = exp_lo.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL rel_to_low_len: got %0d expected %0d", got, e); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rel_to_err_early: got %b expected 0", timeout_err); end
        wait_idle(300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rel_to_idle: got busy expected idle"); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL rel_to_err: got %b expected 1", timeout_err); end
        ack_mode = 0;
    endtask

    task automatic test_async_scan();
        bit ok;
        pulse_sw();
        repeat (5) @(negedge dclk);
        #2 arst_n = 1'b0;
        #1;
        checks++; if ({rst_out_n, busy, cause, timeout_err} !== 6'b0) begin errors++; $display("FAIL async_abort: got rst=%b busy=%b cause=%b err=%b expected all 0", rst_out_n, busy, cause, timeout_err); end
        scan_mode = 1'b1;
        clk_en = 1'b0;
        #1;
        checks++; if (rst_out_n !== 1'b0) begin errors++; $display("FAIL scan_low: got %b expected 0", rst_out_n); end
        #20 arst_n = 1'b1;
        #1;
        checks++; if (rst_out_n !== 1'b1) begin errors++; $display("FAIL scan_high: got %b expected 1", rst_out_n); end
        #5 arst_n = 1'b0;
        #1;
        checks++; if (rst_out_n !== 1'b0) begin errors++; $display("FAIL scan_low2: got %b expected 0", rst_out_n); end
        #5 arst_n = 1'b1;
        #1;
        checks++; if (rst_out_n !== 1'b1) begin errors++; $display("FAIL scan_high2: got %b expected 1", rst_out_n); end
        clk_en = 1'b1;
        @(negedge dclk);
        pulse_sw();
        checks++; if ({rst_out_n, busy} !== 2'b11) begin errors++; $display("FAIL scan_fsm_runs: got rst=%b busy=%b expected rst=1 busy=1", rst_out_n, busy); end
        scan_mode = 1'b0;
        #1;
        checks++; if (rst_out_n !== 1'b0) begin errors++; $display("FAIL scan_exit_assert: got %b expected 0", rst_out_n); end
        wait_idle(300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL scan_event_idle: got busy expected idle"); end
    endtask

    initial begin
        test_reset();
        test_sw_pulse();
        test_wdt_level();
        test_pending();
        test_assert_absorb();
        test_timeout();
        test_cause_clr();
        test_release_timeout();
        test_async_scan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no completion expected finish");
        $fatal(1, "bench time limit expired");
    end

endmodule
